// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the pipeline hazard controller
//
// Purpose: common definitions imported by hazard_unit_mc and its sub-module.
//   ADDR_WIDTH_DEF : default register-address width of the core
//   LD_ADDR_W      : address field width of a load-tracker entry; any
//                    ADDR_WIDTH up to this value is stored losslessly
//   ld_entry_t     : one in-flight load {valid, addr}
package hazard_pkg;

   localparam int ADDR_WIDTH_DEF = 5;
   localparam int LD_ADDR_W      = 8;

   typedef struct packed {
      logic                 valid;
      logic [LD_ADDR_W-1:0] addr;
   } ld_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - zero-aware source-operand match against one tracked address
//
// Purpose: hit = en & (rs_used & rs_addr==addr | rt_used & rt_addr==addr),
//          with matches on address 0 suppressed when ZERO_REG_EN != 0.
// Ports:
//   en        in  tracked address is live (load / busy MDU entry)
//   addr      in  tracked destination address
//   rs_addr   in  rs of the ID instruction
//   rt_addr   in  rt of the ID instruction
//   rs_used   in  ID instruction reads rs
//   rt_used   in  ID instruction reads rt
//   hit       out ID instruction depends on addr
module hazard_src_match
   import hazard_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int ZERO_REG_EN = 1
) (
   input  logic                  en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [ADDR_WIDTH-1:0] rs_addr,
   input  logic [ADDR_WIDTH-1:0] rt_addr,
   input  logic                  rs_used,
   input  logic                  rt_used,
   output logic                  hit
);

   logic zero_ignored;

   // Register 0 is hard-wired; a "write" to it never produces data to wait for.
   assign zero_ignored = (ZERO_REG_EN != 0) && (addr == '0);

   assign hit = en & ~zero_ignored &
                ((rs_used & (rs_addr == addr)) | (rt_used & (rt_addr == addr)));

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - multi-cycle load-use / MDU / branch hazard controller
//
// Purpose: sits beside ID and generates PC hold, IF/ID hold, ID/EX control
//          clear and IF flush; counts stall cycles with saturation.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid                   ID holds a real instruction
//   regS_addr_id, regT_addr_id ID source addresses
//   rs_used_id, rt_used_id     ID sources actually read
//   dest_addr_id               ID destination (captured on MDU issue)
//   mdu_op_id                  ID instruction is an MDU op
//   branch_taken               branch resolved taken in ID
//   mem_rd_en_ex, regT_addr_ex load in EX and its destination
//   ex_valid                   EX holds a real instruction
//   clear_ctrl                 bubble into ID/EX
//   hold_if, hold_pc           freeze IF/ID and PC
//   if_flush                   squash IF/ID
//   stall_cycles               saturating stall-cycle count
module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int LOAD_LAT     = 1,
   parameter int MDU_LAT      = 4,
   parameter int FLUSH_CYCLES = 1,
   parameter int ZERO_REG_EN  = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [ADDR_WIDTH-1:0] regS_addr_id,
   input  logic [ADDR_WIDTH-1:0] regT_addr_id,
   input  logic                  rs_used_id,
   input  logic                  rt_used_id,
   input  logic [ADDR_WIDTH-1:0] dest_addr_id,
   input  logic                  mdu_op_id,
   input  logic                  branch_taken,
   input  logic                  mem_rd_en_ex,
   input  logic [ADDR_WIDTH-1:0] regT_addr_ex,
   input  logic                  ex_valid,
   output logic                  clear_ctrl,
   output logic                  hold_if,
   output logic                  hold_pc,
   output logic                  if_flush,
   output logic [CNT_W-1:0]      stall_cycles
);

   localparam int MDU_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
   localparam int FL_W  = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

   logic                  ex_ld_live;
   logic                  ex_ld_hit;
   logic                  ld_trk_hit;
   logic                  stall_ld;
   logic                  stall_mdu;
   logic                  stall;
   logic                  br;
   logic                  mdu_busy;
   logic                  mdu_hit;
   logic                  mdu_issue;
   logic [MDU_W-1:0]      mdu_cnt;
   logic [ADDR_WIDTH-1:0] mdu_dest;
   logic [FL_W-1:0]       fl_cnt;

   // ---------------------------------------------------------------- loads
   assign ex_ld_live = mem_rd_en_ex & ex_valid;

   hazard_src_match #(.ADDR_WIDTH(ADDR_WIDTH), .ZERO_REG_EN(ZERO_REG_EN)) u_ex_match (
      .en      (ex_ld_live),
      .addr    (regT_addr_ex),
      .rs_addr (regS_addr_id),
      .rt_addr (regT_addr_id),
      .rs_used (rs_used_id),
      .rt_used (rt_used_id),
      .hit     (ex_ld_hit)
   );

   // Loads keep flowing past EX regardless of stalls, so the tracker shifts
   // every cycle; entry 0 here is the load one cycle past EX.
   generate
      if (LOAD_LAT > 1) begin : g_ld
         localparam int N = LOAD_LAT - 1;
         ld_entry_t      ld_q [N];
         logic [N-1:0]   hit;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < N; i++) ld_q[i] <= '0;
            end else begin
               ld_q[0].valid <= ex_ld_live;
               ld_q[0].addr  <= LD_ADDR_W'(regT_addr_ex);
               for (int i = 1; i < N; i++) ld_q[i] <= ld_q[i-1];
            end
         end

         for (genvar g = 0; g < N; g++) begin : g_match
            hazard_src_match #(.ADDR_WIDTH(ADDR_WIDTH), .ZERO_REG_EN(ZERO_REG_EN)) u_ld_match (
               .en      (ld_q[g].valid),
               .addr    (ADDR_WIDTH'(ld_q[g].addr)),
               .rs_addr (regS_addr_id),
               .rt_addr (regT_addr_id),
               .rs_used (rs_used_id),
               .rt_used (rt_used_id),
               .hit     (hit[g])
            );
         end

         assign ld_trk_hit = |hit;
      end else begin : g_no_ld
         assign ld_trk_hit = 1'b0;
      end
   endgenerate

   assign stall_ld = id_valid & (ex_ld_hit | ld_trk_hit);

   // ------------------------------------------------------------------ MDU
   assign mdu_busy = (mdu_cnt != '0);

   hazard_src_match #(.ADDR_WIDTH(ADDR_WIDTH), .ZERO_REG_EN(ZERO_REG_EN)) u_mdu_match (
      .en      (mdu_busy),
      .addr    (mdu_dest),
      .rs_addr (regS_addr_id),
      .rt_addr (regT_addr_id),
      .rs_used (rs_used_id),
      .rt_used (rt_used_id),
      .hit     (mdu_hit)
   );

   // The MDU is single-occupancy: a second MDU op waits even without a data dependency.
   assign stall_mdu = id_valid & mdu_busy & (mdu_op_id | mdu_hit);
   assign stall     = stall_ld | stall_mdu;
   assign mdu_issue = id_valid & mdu_op_id & ~stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdu_cnt  <= '0;
         mdu_dest <= '0;
      end else if (mdu_issue) begin
         mdu_cnt  <= MDU_W'(MDU_LAT - 1);
         mdu_dest <= dest_addr_id;
      end else if (mdu_busy) begin
         mdu_cnt  <= mdu_cnt - MDU_W'(1);
      end
   end

   // --------------------------------------------------------------- branch
   // A stalled branch may be reading stale operands, so it is not taken until
   // the stall clears.
   assign br = branch_taken & id_valid & ~stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fl_cnt <= '0;
      end else if (br) begin
         fl_cnt <= FL_W'(FLUSH_CYCLES - 1);
      end else if (fl_cnt != '0) begin
         fl_cnt <= fl_cnt - FL_W'(1);
      end
   end

   // -------------------------------------------------------------- outputs
   assign clear_ctrl = stall | br;
   assign hold_if    = stall;
   assign hold_pc    = stall;
   assign if_flush   = br | (fl_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - scoreboard testbench for hazard_unit_mc
module tb_hazard_unit_mc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] regS_addr_id = '0, regT_addr_id = '0, dest_addr_id = '0, regT_addr_ex = '0;
   logic       rs_used_id = 1'b0, rt_used_id = 1'b0, mdu_op_id = 1'b0;
   logic       branch_taken = 1'b0, mem_rd_en_ex = 1'b0, ex_valid = 1'b0;

   logic        a_clr, a_hif, a_hpc, a_fl;
   logic [3:0]  a_cnt;
   logic        b_clr, b_hif, b_hpc, b_fl;
   logic [15:0] b_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic clr, hold, fl;
      int   cnt;
      logic chk_b, b_hold;
      int   b_cnt;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   hazard_unit_mc #(.LOAD_LAT(3), .MDU_LAT(4), .FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .regS_addr_id(regS_addr_id), .regT_addr_id(regT_addr_id),
      .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
      .dest_addr_id(dest_addr_id), .mdu_op_id(mdu_op_id), .branch_taken(branch_taken),
      .mem_rd_en_ex(mem_rd_en_ex), .regT_addr_ex(regT_addr_ex), .ex_valid(ex_valid),
      .clear_ctrl(a_clr), .hold_if(a_hif), .hold_pc(a_hpc), .if_flush(a_fl),
      .stall_cycles(a_cnt)
   );

   hazard_unit_mc #(.LOAD_LAT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .regS_addr_id(regS_addr_id), .regT_addr_id(regT_addr_id),
      .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
      .dest_addr_id(dest_addr_id), .mdu_op_id(mdu_op_id), .branch_taken(branch_taken),
      .mem_rd_en_ex(mem_rd_en_ex), .regT_addr_ex(regT_addr_ex), .ex_valid(ex_valid),
      .clear_ctrl(b_clr), .hold_if(b_hif), .hold_pc(b_hpc), .if_flush(b_fl),
      .stall_cycles(b_cnt)
   );

   task automatic chk(input int v, input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL vec%0d %s actual=%0d expected=%0d", v, nm, act, expv);
      end
   endtask

   // One vector per cycle: inputs change just after the rising edge, the
   // expected response is queued, and the monitor compares at the falling edge.
   task automatic cyc(input logic rn, input logic iv,
                      input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu,
                      input logic mop, input logic [4:0] dst, input logic brt,
                      input logic ldv, input logic [4:0] lrt,
                      input logic c, input logic h, input logic f, input int n,
                      input logic cb = 1'b0, input logic bh = 1'b0, input int bn = 0);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n        = rn;
      id_valid     = iv;
      regS_addr_id = rs;
      rs_used_id   = rsu;
      regT_addr_id = rt;
      rt_used_id   = rtu;
      mdu_op_id    = mop;
      dest_addr_id = dst;
      branch_taken = brt;
      mem_rd_en_ex = ldv;
      ex_valid     = ldv;
      regT_addr_ex = lrt;
      e.clr = c; e.hold = h; e.fl = f; e.cnt = n;
      e.chk_b = cb; e.b_hold = bh; e.b_cnt = bn;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      int   v;
      exp_t e;
      v = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(v, "clear_ctrl", int'(a_clr), int'(e.clr));
            chk(v, "hold_if", int'(a_hif), int'(e.hold));
            chk(v, "hold_pc", int'(a_hpc), int'(e.hold));
            chk(v, "if_flush", int'(a_fl), int'(e.fl));
            chk(v, "stall_cycles", int'(a_cnt), e.cnt);
            if (e.chk_b) begin
               chk(v, "b_hold_if", int'(b_hif), int'(e.b_hold));
               chk(v, "b_clear_ctrl", int'(b_clr), int'(e.b_hold));
               chk(v, "b_stall_cycles", int'(b_cnt), e.b_cnt);
            end
            v++;
         end
      end
   end

   initial begin : driver
      //   rn iv rs  su rt  tu mop dst br ld lrt  clr hld fl cnt  [chkB bhold bcnt]
      // reset, then idle
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0);
      // load r5 in EX, ID reads rs=r5: LOAD_LAT=3 stalls 3 cycles, LOAD_LAT=1 stalls 1
      cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 5,  1, 1, 0, 0,  1, 1, 0);
      cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1,  1, 0, 1);
      cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 2,  1, 0, 1);
      cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3,  1, 0, 1);
      // load r7, ID reads rt=r7: 3 stall cycles
      cyc(1, 1, 0, 0, 7, 1, 0, 0, 0, 1, 7,  1, 1, 0, 3);
      cyc(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0,  1, 1, 0, 4);
      cyc(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0,  1, 1, 0, 5);
      cyc(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0,  0, 0, 0, 6);
      // r0 sources and an unused rt never stall
      cyc(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0,  0, 0, 0, 6);
      cyc(1, 1, 3, 1, 7, 0, 0, 0, 0, 1, 7,  0, 0, 0, 6);
      cyc(1, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 6);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 6);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 6);
      // MDU op -> r9 issues; reader of r9 stalls 3 cycles, leaves on cycle 4
      cyc(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0,  0, 0, 0, 6);
      cyc(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 6);
      cyc(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 7);
      cyc(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 8);
      cyc(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 9);
      // back-to-back independent MDU ops: the second waits for mdu_cnt=0
      cyc(1, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 9);
      cyc(1, 1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 1, 1, 0, 9);
      cyc(1, 1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 1, 1, 0, 10);
      cyc(1, 1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 1, 1, 0, 11);
      cyc(1, 1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 12);
      // reset in the middle of an MDU stall
      cyc(1, 1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 1, 1, 0, 12);
      cyc(0, 1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // taken branch, no hazard: 2-cycle flush, clear_ctrl only in the first
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
      // branch depending on a load: stalls without flushing, then is taken
      cyc(1, 1, 4, 1, 0, 0, 0, 0, 1, 1, 4,  1, 1, 0, 0);
      cyc(1, 1, 4, 1, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 1);
      cyc(1, 1, 4, 1, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 2);
      cyc(1, 1, 4, 1, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 3);
      // reset in the middle of the flush
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
      // branch during an active flush re-arms it
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
      // 20 stalled cycles: 4-bit counter saturates at 15
      for (int i = 0; i < 20; i++)
         cyc(1, 1, 6, 1, 0, 0, 0, 0, 0, 1, 6, 1, 1, 0, (i > 15) ? 15 : i);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 15);

      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
      @(posedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised pipeline hazard controller for the 5-stage core, successor to the single-cycle load-use/branch hazard detector. Sits beside the ID stage and drives the PC hold, IF/ID hold, ID/EX control-clear and IF flush signals. It adds four things:
- multi-cycle load-use tracking across a configurable memory latency;
- a busy scoreboard for a multi-cycle multiply/divide unit (MDU);
- multi-cycle branch flush;
- a saturating stall-cycle counter.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width
- LOAD_LAT, 1, cycles from load in EX until its data is forwardable; 1 gives classic single-bubble load-use
- MDU_LAT, 4, MDU occupancy in cycles; ≥2
- FLUSH_CYCLES, 1, IF flush length after a taken branch; ≥1
- ZERO_REG_EN, 1, when 1, address 0 never creates a hazard
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- regS_addr_id  in  ADDR_WIDTH  rs of ID instruction
- regT_addr_id  in  ADDR_WIDTH  rt of ID instruction
- rs_used_id, rt_used_id  in  1 each  source actually read
- dest_addr_id  in  ADDR_WIDTH  destination of ID instruction
- mdu_op_id  in  1  ID instruction is an MDU op
- branch_taken  in  1  branch resolved taken in ID
- mem_rd_en_ex  in  1  EX instruction is a load
- regT_addr_ex  in  ADDR_WIDTH  load destination in EX
- ex_valid  in  1  EX holds a real instruction
- clear_ctrl  out  1  zero ID/EX control (bubble)
- hold_if  out  1  hold IF/ID register
- hold_pc  out  1  hold PC
- if_flush  out  1  squash IF/ID contents
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- **Source match:** `src_hit(a)` = (rs_used_id & regS_addr_id==a) | (rt_used_id & regT_addr_id==a). With ZERO_REG_EN, matches on a==0 are ignored.
- **Load tracker:** shift register `ld[1..LOAD_LAT-1]` of {valid, addr}; absent when LOAD_LAT=1.
  - Each cycle, `ld[1]` <= {mem_rd_en_ex & ex_valid, regT_addr_ex} and `ld[i]` <= `ld[i-1]`.
  - It advances unconditionally; stalls never freeze EX and later stages.
- **stall_ld** = id_valid & (src_hit(EX load addr) when mem_rd_en_ex & ex_valid, OR src_hit(ld[i].addr) for any valid ld[i]).
- **MDU scoreboard:** down-counter `mdu_cnt` plus `mdu_dest`.
  - stall_mdu = id_valid & mdu_cnt≠0 & (mdu_op_id | src_hit(mdu_dest)).
  - Issue = id_valid & mdu_op_id & ~stall: load mdu_cnt=MDU_LAT-1 and mdu_dest=dest_addr_id.
  - Otherwise mdu_cnt decrements to 0 and holds there.
- **Combined stall** = stall_ld | stall_mdu.
- **Branch:** br = branch_taken & id_valid & ~stall. A branch whose operands are pending is stalled, not taken.
  - On br: if_flush is asserted that cycle, and flush counter `fl_cnt` loads FLUSH_CYCLES-1.
  - if_flush = br | fl_cnt≠0; fl_cnt decrements to 0.
  - br during an active flush re-arms the counter.
- **Outputs:**
  - clear_ctrl = stall | br
  - hold_if = hold_pc = stall
- **stall_cycles** increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- All outputs except stall_cycles are combinational from inputs plus state, valid in the same cycle.
- State updates on the rising edge.
- Reset (async, any time, including mid-MDU or mid-flush): all ld entries invalid, mdu_cnt=0, fl_cnt=0, stall_cycles=0.
  - With id_valid=0, all outputs read 0 during and after reset.
- Load-use stall length for a dependent instruction directly behind a load: LOAD_LAT cycles.
- MDU dependents stall MDU_LAT-1 cycles after issue, so the consumer leaves ID on cycle MDU_LAT after issue.
- Simultaneous stall and branch_taken: stall wins, no flush. The branch re-evaluates when the stall clears.

## Structure
- Shared package `hazard_pkg`: a localparam for the default ADDR_WIDTH, and the typedef `ld_entry_t` {valid, addr}.
- One sub-module, `hazard_src_match`: the zero-aware comparator implementing src_hit, instantiated per tracked address.

## Test plan
- LOAD_LAT=1; load r5 in EX, ID reads rs=r5 → stall, clear_ctrl, hold_if and hold_pc all 1 for exactly 1 cycle; stall_cycles=1.
- LOAD_LAT=3; load r7, then ID reads rt=r7 → stall 3 cycles. A source of r0 or unused rt=r7 → no stall.
- MDU_LAT=4; MDU op writing r9 issues, next ID reads r9 → stall 3 cycles. A second MDU op also stalls until mdu_cnt=0.
- FLUSH_CYCLES=2; branch_taken with no hazard → if_flush=1 for 2 cycles, clear_ctrl=1 only in the first. With a concurrent load-use hazard → no flush while stalled.
- Assert rst_n low mid-MDU-stall and mid-flush → all outputs drop to 0 immediately, and stall_cycles=0.
- CNT_W=4; hold stall for 20 cycles → stall_cycles saturates at 15.
